// File: rtl/aemb2_wb_timer.sv
// aeMB2 Wishbone timer: auto-reload down-counter with a level interrupt.
// Optional prescaler (PRESC at index 4) is built when AEMB2_TMR_PRESCALE_EN is defined.
module aemb2_wb_timer #(
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:2] twb_adr_o,
  input  logic [31:0]   twb_dat_o,
  input  logic [3:0]    twb_sel_o,
  input  logic          twb_stb_o,
  input  logic          twb_cyc_o,
  input  logic          twb_wre_o,
  input  logic          twb_tag_o,
  output logic [31:0]   twb_dat_i,
  output logic          twb_ack_i,
  output logic          tmr_int_o
);

  logic          ctrl_en;
  logic          ctrl_ie;
  logic          ctrl_reload;
  logic          pend;
  logic [CW-1:0] load_q;
  logic [CW-1:0] count_q;
  logic          tick;
  logic          zero_evt;
  logic [2:0]    idx;
  logic          bus_req;
  logic          bus_wr;
  logic [31:0]   rd_data;
  logic [31:0]   wr_val;
  logic [31:0]   presc_rd;
  logic          unused_tag;

  assign unused_tag = twb_tag_o;
  assign idx        = twb_adr_o[4:2];
  assign bus_req    = twb_stb_o & twb_cyc_o & ~twb_ack_i;
  assign bus_wr     = bus_req & twb_wre_o;
  assign zero_evt   = tick & (count_q == '0);

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = {29'b0, ctrl_reload, ctrl_ie, ctrl_en};
      3'd1:    rd_data = {31'b0, pend};
      3'd2:    rd_data = 32'(load_q);
      3'd3:    rd_data = 32'(count_q);
      3'd4:    rd_data = presc_rd;
      default: rd_data = '0;
    endcase
  end

  // Merging the selected lanes into the current read value gives the new
  // register contents for whichever register is addressed.
  always_comb begin
    wr_val = rd_data;
    for (int b = 0; b < 4; b++) begin
      if (twb_sel_o[b]) wr_val[8*b +: 8] = twb_dat_o[8*b +: 8];
    end
  end

`ifdef AEMB2_TMR_PRESCALE_EN
  logic [15:0] presc_q;
  logic [15:0] presc_cnt;

  assign tick     = ctrl_en & (presc_cnt == presc_q);
  assign presc_rd = {16'b0, presc_q};

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      presc_q   <= '0;
      presc_cnt <= '0;
    end else begin
      if (bus_wr && idx == 3'd4) presc_q <= wr_val[15:0];
      if (!ctrl_en || tick || (bus_wr && idx == 3'd4)) presc_cnt <= '0;
      else presc_cnt <= presc_cnt + 16'd1;
    end
  end
`else
  assign tick     = ctrl_en;
  assign presc_rd = '0;
`endif

  // Bus writes are applied after the counting logic so they take priority,
  // except that a zero event always leaves PEND set.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      ctrl_en     <= 1'b0;
      ctrl_ie     <= 1'b0;
      ctrl_reload <= 1'b0;
      pend        <= 1'b0;
      load_q      <= '0;
      count_q     <= '0;
    end else begin
      if (tick) begin
        if (count_q != '0) count_q <= count_q - CW'(1);
        else if (ctrl_reload) count_q <= load_q;
      end
      if (zero_evt && !ctrl_reload) ctrl_en <= 1'b0;

      if (zero_evt) pend <= 1'b1;
      else if (bus_wr && idx == 3'd1 && twb_sel_o[0] && twb_dat_o[0]) pend <= 1'b0;

      if (bus_wr) begin
        case (idx)
          3'd0: begin
            ctrl_en     <= wr_val[0];
            ctrl_ie     <= wr_val[1];
            ctrl_reload <= wr_val[2];
          end
          3'd2:    load_q  <= wr_val[CW-1:0];
          3'd3:    count_q <= wr_val[CW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      twb_ack_i <= 1'b0;
      twb_dat_i <= '0;
      tmr_int_o <= 1'b0;
    end else begin
      twb_ack_i <= bus_req;
      twb_dat_i <= bus_req ? rd_data : 32'd0;
      tmr_int_o <= pend & ctrl_ie;
    end
  end

endmodule
